// File: rtl/sq_diff_pkg.sv
// Shared width helpers and term-mode encoding for the squared/absolute
// difference frame accumulator.
package sq_diff_pkg;

  localparam logic MODE_SQ  = 1'b0;
  localparam logic MODE_ABS = 1'b1;

  function automatic int diff_w(input int w);
    return w + 1;
  endfunction

  function automatic int term_w(input int w);
    return 2 * w + 2;
  endfunction

  // A frame of n full-scale squares is below n * 2^(2w); the clog2(n) headroom bits cover it.
  function automatic int acc_w(input int w, input int n);
    return 2 * w + 2 + $clog2(n);
  endfunction

endpackage

// File: rtl/sq_diff_term.sv
// Three-stage term pipeline: register operands, register the widened difference,
// then register either its square or its magnitude, chosen per sample.
module sq_diff_term
  import sq_diff_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic                   in_mode,
  output logic                   out_valid,
  output logic [term_w(W)-1:0]   term
);

  localparam int DIFF_W = diff_w(W);
  localparam int TERM_W = term_w(W);

  logic                     s1_valid;
  logic [W-1:0]             s1_a;
  logic [W-1:0]             s1_b;
  logic                     s1_mode;
  logic                     s2_valid;
  logic signed [DIFF_W-1:0] s2_diff;
  logic                     s2_mode;
  logic                     s3_valid;
  logic [TERM_W-1:0]        s3_term;

  logic signed [DIFF_W-1:0] s1_diff;
  logic signed [TERM_W-1:0] s2_ext;
  logic [TERM_W-1:0]        s2_sq;
  logic [DIFF_W-1:0]        s2_mag;
  logic [TERM_W-1:0]        s2_term;

  // One extra bit makes a - b exact for every pair of W-bit signed operands.
  assign s1_diff = {s1_a[W-1], s1_a} - {s1_b[W-1], s1_b};

  assign s2_ext  = {{(TERM_W-DIFF_W){s2_diff[DIFF_W-1]}}, s2_diff};
  assign s2_sq   = s2_ext * s2_ext;
  // The most negative difference is -(2^W - 1), so negation never wraps.
  assign s2_mag  = s2_diff[DIFF_W-1] ? -s2_diff : s2_diff;
  assign s2_term = (s2_mode == MODE_ABS) ? {{(TERM_W-DIFF_W){1'b0}}, s2_mag} : s2_sq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_SQ;
      s2_valid <= 1'b0;
      s2_diff  <= '0;
      s2_mode  <= MODE_SQ;
      s3_valid <= 1'b0;
      s3_term  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
      s1_mode  <= in_mode;
      s2_valid <= s1_valid;
      s2_diff  <= s1_diff;
      s2_mode  <= s1_mode;
      s3_valid <= s2_valid;
      s3_term  <= s2_term;
    end
  end

  assign out_valid = s3_valid;
  assign term      = s3_term;

endmodule

// File: rtl/sq_diff_acc.sv
// Frame accumulator: sums N per-sample terms and presents the unsigned total
// on a valid/ready output register.
module sq_diff_acc
  import sq_diff_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [acc_w(W,N)-1:0]  out_data
);

  localparam int TERM_W = term_w(W);
  localparam int ACC_W  = acc_w(W, N);
  localparam int CNT_W  = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Valid never waits on ready; the whole datapath freezes only while an
  // output sum is held unconsumed, and in_ready mirrors that condition.
  logic              advance;
  logic              term_valid;
  logic [TERM_W-1:0] term;
  logic [ACC_W-1:0]  term_ext;
  logic [ACC_W-1:0]  acc_sum;
  logic              complete;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  sq_diff_term #(
    .W (W)
  ) u_term (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .in_mode   (in_mode),
    .out_valid (term_valid),
    .term      (term)
  );

  assign term_ext = {{(ACC_W-TERM_W){1'b0}}, term};
  assign acc_sum  = acc + term_ext;
  assign complete = term_valid && (count == CNT_LAST);

  // While advancing, a held out_valid implies out_ready, so a finishing frame
  // may reload the output in the same cycle the previous sum is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      if (complete) begin
        out_data  <= acc_sum;
        out_valid <= 1'b1;
        acc       <= '0;
        count     <= '0;
      end else begin
        out_valid <= 1'b0;
        if (term_valid) begin
          acc   <= acc_sum;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sq_diff_acc.sv
// Directed and randomized checks of sq_diff_acc (W=16, N=4) against a
// frame-sum reference model and an expected-sum queue.
module tb_sq_diff_acc;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int ACC_W = 2 * W + 2 + $clog2(N);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_data;

  int tests = 0;
  int fails = 0;

  logic [ACC_W-1:0] exp_q[$];
  longint           m_sum = 0;
  int               m_cnt = 0;
  int               frames_pushed = 0;
  int               frames_popped = 0;

  bit                  acc;
  int                  idx, stall, guard, pulses, last_c;
  bit                  seen;
  logic [ACC_W-1:0]    frozen;
  longint              e2;
  logic signed [W-1:0] sa[8];
  logic signed [W-1:0] sb[8];
  logic                sm[8];

  // Clock and reset drive
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  sq_diff_acc #(
    .W (W),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference term from plain integer arithmetic.
  function automatic longint term_of(input logic signed [W-1:0] x,
                                     input logic signed [W-1:0] y,
                                     input logic m);
    longint d;
    d = longint'(x) - longint'(y);
    if (m) return (d < 0) ? -d : d;
    return d * d;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, update the model, step the clock.
  task automatic cycle(output bit accepted);
    #3;
    accepted = 1'b0;
    if (rst) begin
      m_sum = 0;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("sb_out_data", out_data, exp_q.pop_front());
          frames_popped++;
        end
      end
      if (in_valid && in_ready) begin
        accepted = 1'b1;
        m_sum += term_of(a, b, in_mode);
        m_cnt++;
        if (m_cnt == N) begin
          exp_q.push_back(ACC_W'(m_sum));
          m_sum = 0;
          m_cnt = 0;
          frames_pushed++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit t;
    in_valid = 1'b0;
    repeat (n) cycle(t);
  endtask

  task automatic send(input int x, input int y, input logic m);
    bit t;
    int k;
    a        = W'(x);
    b        = W'(y);
    in_mode  = m;
    in_valid = 1'b1;
    t = 1'b0;
    k = 0;
    while (!t && k < 50) begin
      cycle(t);
      k++;
    end
    if (!t) check("send_accept_timeout", t, 1);
  endtask

  task automatic wait_out(input string tag, input logic [ACC_W-1:0] exp);
    bit t;
    int k;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin
      cycle(t);
      k++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    cycle(acc);
    cycle(acc);
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 1);

    // Basic frame and four-cycle latency from the last accept.
    repeat (4) send(3, 1, 1'b0);
    check("lat_edge1", out_valid, 0);
    idle(1);
    check("lat_edge2", out_valid, 0);
    idle(1);
    check("lat_edge3", out_valid, 0);
    idle(1);
    check("lat_edge4_valid", out_valid, 1);
    check("lat_edge4_data", out_data, 16);
    idle(1);
    check("pulse_one_cycle", out_valid, 0);

    // Extreme operands must not wrap.
    repeat (4) send(-32768, 32767, 1'b0);
    wait_out("wide_no_wrap", 36'd17179344900);
    idle(1);

    // Absolute mode and a mixed-mode frame.
    repeat (4) send(5, 9, 1'b1);
    wait_out("abs_mode", 16);
    idle(1);
    send(3, 1, 1'b0);
    send(5, 9, 1'b1);
    send(0, 0, 1'b0);
    send(-2, 2, 1'b1);
    wait_out("mixed_mode", 12);
    idle(1);

    // Backpressure: output held, input stalled, no sample lost.
    for (int i = 0; i < 8; i++) begin
      sa[i] = W'($urandom_range(0, 65535));
      sb[i] = W'($urandom_range(0, 65535));
      sm[i] = 1'($urandom_range(0, 1));
    end
    e2 = 0;
    for (int i = 4; i < 8; i++) e2 += term_of(sa[i], sb[i], sm[i]);
    out_ready = 1'b0;
    idx   = 0;
    stall = 0;
    guard = 0;
    seen  = 1'b0;
    while (idx < 8 && guard < 100) begin
      a        = sa[idx];
      b        = sb[idx];
      in_mode  = sm[idx];
      in_valid = 1'b1;
      cycle(acc);
      guard++;
      if (acc) idx++;
      if (out_valid && !out_ready) begin
        if (!seen) begin
          frozen = out_data;
          seen   = 1'b1;
          check("stall_first_frame", out_data, exp_q[0]);
        end else begin
          check("stall_data_frozen", out_data, frozen);
        end
        check("stall_in_ready_low", in_ready, 0);
        stall++;
        if (stall == 5) out_ready = 1'b1;
      end
    end
    check("stall_all_accepted", idx, 8);
    check("stall_seen", seen, 1);
    wait_out("stall_second_frame", ACC_W'(e2));
    idle(1);

    // Continuous frames of (1,0) with out_ready high.
    out_ready = 1'b1;
    pulses = 0;
    last_c = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 12) begin
        a        = 1;
        b        = 0;
        in_mode  = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle(acc);
      if (c < 12) check("cont_accept", acc, 1);
      if (out_valid) begin
        check("cont_data", out_data, 4);
        if (pulses > 0) check("cont_gap", c - last_c, 4);
        last_c = c;
        pulses++;
      end
    end
    check("cont_pulses", pulses, 3);

    // Reset mid-frame discards the partial frame.
    send(7, 0, 1'b0);
    send(7, 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(acc);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (4) send(2, 0, 1'b0);
    wait_out("midrst_frame", 16);
    idle(1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom_range(0, 65535));
      b         = W'($urandom_range(0, 65535));
      in_mode   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    out_ready = 1'b1;
    idle(10);
    check("sb_drained", exp_q.size(), 0);
    check("frames_balanced", frames_popped, frames_pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sq_diff_acc.md
SQ_DIFF_ACC -- requirements
Module: sq_diff_acc

Interface
REQ-001 SHALL have parameter W, default 16, meaning signed input width.
REQ-002 SHALL have parameter N, default 8, meaning samples per frame (N >= 2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  sample present.
REQ-006 SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  W  signed operand.
REQ-008 SHALL have port b  input  W  signed operand.
REQ-009 SHALL have port in_mode  input  1  per-sample term select: 0 = (a-b)^2, 1 = |a-b|.
REQ-010 SHALL have port out_valid  output  1  frame sum available.
REQ-011 SHALL have port out_ready  input  1  frame sum consumed when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  ACC_W  unsigned frame sum, ACC_W = 2W+2+clog2(N).

Function
REQ-013 SHALL compute diff = a - b at W+1 bits signed with no overflow.
REQ-014 SHALL form the term as diff*diff at 2W+2 bits (mode 0) or |diff| zero-extended (mode 1).
REQ-015 SHALL carry in_mode with its sample through the pipeline, so mixed modes within a frame apply per sample.
REQ-016 SHALL pipeline as S1 register a/b/mode, S2 register diff, S3 register term, then accumulate, each stage with its own valid bit.
REQ-017 SHALL define advance = !(out_valid && !out_ready); all stages, counter and accumulator hold when advance is 0.
REQ-018 SHALL drive in_ready = advance (combinational, no input skid).
REQ-019 SHALL, on each advancing cycle with a valid S3 term, add the term to acc and increment count modulo N.
REQ-020 SHALL, when count == N-1 and S3 is valid on an advancing cycle, load out_data = acc + term, set out_valid, and clear acc and count to 0 in the same cycle.
REQ-021 SHALL give a latency of 4 cycles from acceptance of the frame's last sample to out_valid high, with no backpressure.
REQ-022 SHALL hold out_data stable while out_valid && !out_ready.
REQ-023 SHALL, when out_valid && out_ready coincides with a new frame completion, keep out_valid high and present the new sum the next cycle, with no bubble.
REQ-024 SHALL clear out_valid on handshake when no new frame completes.
REQ-025 SHALL sustain one sample per cycle with out_ready held high.
REQ-026 SHALL never overflow: ACC_W covers N * 2^(2W).

Reset
REQ-027 SHALL, on rst, clear all stage valid bits, count, acc, out_valid and out_data to 0 at the next edge, discarding any partial frame and in-flight samples.
REQ-028 SHALL hold in_ready at 1 in the cycle after reset, since out_valid is 0.
REQ-029 SHALL give rst priority over any simultaneous handshake.

Structure
REQ-030 SHALL place the width functions (DIFF_W = W+1, TERM_W = 2W+2, ACC_W) and the mode encoding constants in package sq_diff_pkg.
REQ-031 SHALL implement S1–S3 as sub-module sq_diff_term, with valid, enable and mode ports; the accumulator, counter and output register stay in sq_diff_acc.

Verification (W=16, N=4)
REQ-032 SHALL cover: four samples a=3, b=1, mode 0, back to back with out_ready=1 -> out_data=16, out_valid high for 1 cycle, 4 cycles after the 4th accept.
REQ-033 SHALL cover: four samples a=-32768, b=32767, mode 0 -> out_data=17179344900, with no wrap.
REQ-034 SHALL cover: four samples a=5, b=9, mode 1 -> out_data=16; a mixed frame of (3,1,m0), (5,9,m1), (0,0,m0), (-2,2,m1) -> out_data=12.
REQ-035 SHALL cover: out_ready=0 after a frame completes while samples keep arriving -> in_ready=0 the cycle after out_valid rises, out_data frozen, no sample lost; releasing out_ready yields the second frame sum unchanged.
REQ-036 SHALL cover: continuous frames of (1,0,m0) with out_ready=1 -> out_valid pulses every 4 cycles with out_data=4, and no bubble at the handshake/completion overlap.
REQ-037 SHALL cover: rst asserted after 2 samples of a frame, then four samples of (2,0,m0) -> out_data=16, the pre-reset samples not included.
